// File: rtl/slave_in_port.sv
// slave_in_port: slave-side serial frame receiver; decodes select/cmd/addr/burst and emits memory writes or a read request
//   clk, rst                  : clock, asynchronous active-high reset
//   master_valid, rx_bit      : frame qualifier and LSB-first serial data
//   slave_ready, selected     : idle indicator, frame-addressed-to-us indicator
//   mem_wen/mem_addr/mem_wdata: one-cycle write strobe per received word
//   read_req/read_addr/read_burst_num : one-cycle read request for read frames
//   rx_done, frame_err        : frame completed / selected frame truncated pulses
module slave_in_port #(
  parameter int SLAVE_LEN = 2,
  parameter int ADDRESS_LEN = 12,
  parameter int WORD_SIZE = 8,
  parameter int BURST_SIZE = 12,
  parameter int SLAVE_ID = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   master_valid,
  input  logic                   rx_bit,
  output logic                   slave_ready,
  output logic                   selected,
  output logic                   mem_wen,
  output logic [ADDRESS_LEN-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]   mem_wdata,
  output logic                   read_req,
  output logic [ADDRESS_LEN-1:0] read_addr,
  output logic [BURST_SIZE-1:0]  read_burst_num,
  output logic                   rx_done,
  output logic                   frame_err
);
  localparam int M1 = ADDRESS_LEN > BURST_SIZE ? ADDRESS_LEN : BURST_SIZE;
  localparam int M2 = M1 > WORD_SIZE ? M1 : WORD_SIZE;
  localparam int M3 = M2 > SLAVE_LEN ? M2 : SLAVE_LEN;
  localparam int CW = $clog2(M3 + 1);
  typedef enum logic [2:0] {IDLE, SEL, CMD, ADDR, BURST, DATA, WAIT_LOW} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [SLAVE_LEN-1:0] sel_sr, sel_full;
  logic [ADDRESS_LEN-1:0] addr_sr, addr_full;
  logic [BURST_SIZE-1:0] burst_sr, burst_full, idx;
  logic [WORD_SIZE-1:0] word_sr, word_full;
  logic is_write, armed, last_bit, wr_fire, rd_fire;
  // fields arrive LSB first, so each new bit enters at the MSB
  assign sel_full = {rx_bit, sel_sr[SLAVE_LEN-1:1]};
  assign addr_full = {rx_bit, addr_sr[ADDRESS_LEN-1:1]};
  assign burst_full = {rx_bit, burst_sr[BURST_SIZE-1:1]};
  assign word_full = {rx_bit, word_sr[WORD_SIZE-1:1]};
  assign slave_ready = state == IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    last_bit = state == SEL ? cnt == CW'(SLAVE_LEN - 1) :
               state == ADDR ? cnt == CW'(ADDRESS_LEN - 1) :
               state == BURST ? cnt == CW'(BURST_SIZE - 1) :
               state == DATA ? cnt == CW'(WORD_SIZE - 1) : 1'b1;
    wr_fire = state == DATA && master_valid && last_bit;
    rd_fire = state == BURST && master_valid && last_bit && !is_write;
    state_n = state;
    case (state)
      IDLE: if (master_valid && armed) state_n = SEL;
      WAIT_LOW: if (!master_valid) state_n = IDLE;
      default:
        if (!master_valid) state_n = IDLE;
        else if (last_bit)
          case (state)
            SEL: state_n = sel_full == SLAVE_LEN'(SLAVE_ID) ? CMD : WAIT_LOW;
            CMD: state_n = ADDR;
            ADDR: state_n = BURST;
            BURST: state_n = is_write ? DATA : WAIT_LOW;
            DATA: state_n = idx == burst_sr ? WAIT_LOW : DATA;
            default: state_n = IDLE;
          endcase
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      armed <= 1'b0;
      cnt <= '0;
      sel_sr <= '0;
      is_write <= 1'b0;
      addr_sr <= '0;
      burst_sr <= '0;
      word_sr <= '0;
      idx <= '0;
      selected <= 1'b0;
      mem_wen <= 1'b0;
      read_req <= 1'b0;
      rx_done <= 1'b0;
      frame_err <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      read_addr <= '0;
      read_burst_num <= '0;
    end else begin
      // a frame may only start after a low cycle, so the tail of a frame cut by reset is ignored
      armed <= armed | ~master_valid;
      cnt <= state == IDLE ? CW'(state_n == SEL) : last_bit || !master_valid ? '0 : cnt + CW'(1);
      if (state == SEL || state_n == SEL) sel_sr <= sel_full;
      if (state == CMD) is_write <= rx_bit;
      if (state == ADDR) addr_sr <= addr_full;
      if (state == BURST) burst_sr <= burst_full;
      if (state == DATA) word_sr <= word_full;
      idx <= state == BURST ? '0 : wr_fire ? idx + BURST_SIZE'(1) : idx;
      selected <= state_n inside {CMD, ADDR, BURST, DATA};
      mem_wen <= wr_fire;
      read_req <= rd_fire;
      rx_done <= rd_fire || (wr_fire && idx == burst_sr);
      frame_err <= selected && !master_valid;
      if (wr_fire) begin
        mem_addr <= addr_sr + ADDRESS_LEN'(idx);
        mem_wdata <= word_full;
      end
      if (rd_fire) begin
        read_addr <= addr_sr;
        read_burst_num <= burst_full;
      end
    end
endmodule

// File: tb/tb_slave_in_port.sv
// tb_slave_in_port: randomized and directed frames checked against an event-list model of the receiver
module tb_slave_in_port;
  logic clk = 1'b0;
  logic rst, master_valid, rx_bit;
  logic slave_ready, selected, mem_wen, read_req, rx_done, frame_err;
  logic [11:0] mem_addr, read_addr, read_burst_num;
  logic [7:0] mem_wdata;
  always #5 clk = ~clk;
  slave_in_port #(.SLAVE_LEN(2), .ADDRESS_LEN(12), .WORD_SIZE(8), .BURST_SIZE(12), .SLAVE_ID(1)) dut (
    .clk(clk), .rst(rst), .master_valid(master_valid), .rx_bit(rx_bit),
    .slave_ready(slave_ready), .selected(selected), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .read_req(read_req), .read_addr(read_addr),
    .read_burst_num(read_burst_num), .rx_done(rx_done), .frame_err(frame_err)
  );
  typedef struct packed {
    logic wen, rreq, done, err;
    logic [11:0] addr;
    logic [11:0] data;
    logic [31:0] t;
  } ev_t;
  ev_t obs[$], exp_q[$];
  logic [7:0] wq[$];
  logic bits[$];
  int cyc = 0, passed = 0, fails = 0, total = 0;
  logic sel_seen;
  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask
  task automatic record();
    if (selected) sel_seen = 1'b1;
    if (mem_wen | read_req | rx_done | frame_err)
      obs.push_back('{mem_wen, read_req, rx_done, frame_err,
                      mem_wen ? mem_addr : read_req ? read_addr : 12'h0,
                      mem_wen ? {4'h0, mem_wdata} : read_req ? read_burst_num : 12'h0,
                      32'(cyc)});
  endtask
  task automatic tick(input logic v, input logic b);
    @(negedge clk);
    cyc++;
    record();
    master_valid = v;
    rx_bit = b;
  endtask
  task automatic build(input int sel, input int cmd, input int addr, input int burst);
    bits.delete();
    for (int i = 0; i < 2; i++) bits.push_back(sel[i]);
    bits.push_back(cmd[0]);
    for (int i = 0; i < 12; i++) bits.push_back(addr[i]);
    for (int i = 0; i < 12; i++) bits.push_back(burst[i]);
    if (cmd != 0)
      for (int k = 0; k <= burst; k++)
        for (int i = 0; i < 8; i++) bits.push_back(wq[k][i]);
  endtask
  // expected strobes: a strobe shows one cycle after the edge sampling its completing bit
  task automatic model(input int s, input int sel, input int cmd, input int addr, input int burst, input int len);
    int n = 27 + (cmd != 0 ? (burst + 1) * 8 : 0);
    if (sel != 1) return;
    if (cmd != 0) begin
      for (int k = 0; k <= burst; k++) begin
        int j = 27 + (k + 1) * 8 - 1;
        if (j < len)
          exp_q.push_back('{1'b1, 1'b0, k == burst, 1'b0, 12'((addr + k) % 4096), {4'h0, wq[k]}, 32'(s + j + 1)});
      end
    end else if (len >= n)
      exp_q.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 12'(addr), 12'(burst), 32'(s + 27)});
    if (len < n && len >= 2)
      exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 12'h0, 12'h0, 32'(s + len + 1)});
  endtask
  task automatic send(input int sel, input int cmd, input int addr, input int burst, input int len, input int gap);
    build(sel, cmd, addr, burst);
    if (len < 0 || len > bits.size()) len = bits.size();
    model(cyc + 1, sel, cmd, addr, burst, len);
    sel_seen = 1'b0;
    for (int i = 0; i < len; i++) tick(1'b1, bits[i]);
    for (int i = 0; i < gap; i++) tick(1'b0, 1'b0);
  endtask
  task automatic check_events(string tag);
    chk({tag, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++;
      assert (obs[i] === exp_q[i]) passed++;
      else begin
        fails++;
        $error("FAIL %s ev%0d obs=%h exp=%h", tag, i, obs[i], exp_q[i]);
      end
    end
    obs.delete();
    exp_q.delete();
  endtask
  initial begin
    int sel, cmd, addr, burst, n, len, gap;
    rst = 1'b1;
    master_valid = 1'b0;
    rx_bit = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("rst_ready", slave_ready, 1);
    chk("rst_selected", selected, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rreq", read_req, 0);
    chk("rst_raddr", read_addr, 0);
    chk("rst_burst", read_burst_num, 0);
    chk("rst_done", rx_done, 0);
    chk("rst_err", frame_err, 0);
    rst = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    wq = '{8'hA5};
    send(1, 1, 'h005, 0, -1, 1);
    chk("t1_sel", sel_seen, 1);
    chk("t1_busy", slave_ready, 0);
    tick(1'b0, 1'b0);
    chk("t1_ready", slave_ready, 1);
    tick(1'b0, 1'b0);
    check_events("t1");
    wq = '{8'h11, 8'h22, 8'h33};
    send(1, 1, 'hFFF, 2, -1, 3);
    check_events("t2");
    send(1, 0, 'h0A0, 3, -1, 3);
    check_events("t3");
    wq = '{8'h5A};
    send(2, 1, 'h123, 0, -1, 1);
    chk("t4_nosel", sel_seen, 0);
    wq = '{8'hC3};
    send(1, 1, 'h456, 0, -1, 3);
    chk("t4_sel", sel_seen, 1);
    check_events("t4");
    wq = '{8'h77, 8'h88};
    send(1, 1, 'h010, 1, 27 + 8 + 3, 3);
    chk("t5_ready", slave_ready, 1);
    chk("t5_selected", selected, 0);
    check_events("t5");
    wq = '{8'h99};
    build(1, 1, 'h321, 0);
    for (int i = 0; i < 10; i++) tick(1'b1, bits[i]);
    tick(1'b1, bits[10]);
    rst = 1'b1;
    #1;
    chk("t6_ready", slave_ready, 1);
    chk("t6_selected", selected, 0);
    chk("t6_wen", mem_wen, 0);
    chk("t6_rreq", read_req, 0);
    chk("t6_done", rx_done, 0);
    chk("t6_err", frame_err, 0);
    tick(1'b1, bits[11]);
    rst = 1'b0;
    for (int i = 12; i < bits.size(); i++) tick(1'b1, bits[i]);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    check_events("t6");
    repeat (25) begin
      sel = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 3)) : 1;
      cmd = $urandom_range(0, 1);
      addr = $urandom_range(0, 4095);
      burst = $urandom_range(0, 4);
      wq.delete();
      for (int k = 0; k <= burst; k++) wq.push_back(8'($urandom));
      n = 27 + (cmd != 0 ? (burst + 1) * 8 : 0);
      len = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, n - 1)) : -1;
      gap = $urandom_range(2, 4);
      send(sel, cmd, addr, burst, len, gap);
      check_events("rnd");
    end
    wq.delete();
    for (int k = 0; k < 4096; k++) wq.push_back(8'($urandom));
    send(1, 1, $urandom_range(0, 4095), 4095, -1, 3);
    check_events("max");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/slave_in_port.md
Name: slave_in_port

Overview:
- Slave-side serial receiver for the serial bus; the far end of the master's outgoing port.
- Deserialises one framed serial transfer and checks the slave-select field against its own ID.
- Write frames: emits one parallel memory write per received word.
- Read frames: emits one read request (address + burst count) for the slave's read-out path; signals frame completion and framing errors.

Parameters:
- SLAVE_LEN, 2, width of slave-select field
- ADDRESS_LEN, 12, width of address field
- WORD_SIZE, 8, data word width
- BURST_SIZE, 12, width of burst field (field value = words - 1)
- SLAVE_ID, 1, this slave's select code

Ports:
- clk  in  1  clock, all flops on rising edge
- rst  in  1  asynchronous active-high reset
- master_valid  in  1  frame qualifier; high for every bit of a frame
- rx_bit  in  1  serial data, sampled when master_valid=1
- slave_ready  out  1  high only in IDLE
- selected  out  1  high from select match until the frame ends or aborts
- mem_wen  out  1  one-cycle write strobe
- mem_addr  out  ADDRESS_LEN  write address
- mem_wdata  out  WORD_SIZE  write data
- read_req  out  1  one-cycle read request strobe
- read_addr  out  ADDRESS_LEN  read start address
- read_burst_num  out  BURST_SIZE  read burst field (words - 1)
- rx_done  out  1  one-cycle pulse: frame accepted completely
- frame_err  out  1  one-cycle pulse: selected frame truncated

Behaviour:
- Reset values:
  - slave_ready=1
  - all other outputs 0
  - state=IDLE
  - all shift registers and counters 0
- Frame format: fields are sent LSB first, one bit per cycle with master_valid=1, in this order:
  - SEL (SLAVE_LEN bits)
  - CMD (1 bit: 1=write, 0=read)
  - ADDR (ADDRESS_LEN bits)
  - BURST (BURST_SIZE bits)
  - write only: DATA, (BURST+1) words of WORD_SIZE bits, back to back
- States: IDLE, SEL, CMD, ADDR, BURST, DATA, WAIT_LOW.
- IDLE: a sampled edge with master_valid=1 captures SEL bit 0 and moves to SEL. slave_ready drops the following cycle.
- SEL: after the last select bit is sampled:
  - match with SLAVE_ID: go to CMD, selected=1
  - mismatch: go to WAIT_LOW; no outputs, no frame_err
- CMD, ADDR, BURST: bit counter per field; on the last bit, advance to the next state.
- After BURST:
  - read: read_req=1 and rx_done=1 for one cycle, with read_addr/read_burst_num valid in that cycle; then WAIT_LOW.
  - write: go to DATA with word index 0.
- DATA: on the last bit of each word, assert mem_wen for one cycle, with:
  - mem_wdata = word
  - mem_addr = (ADDR + index) mod 2^ADDRESS_LEN (wrap-around required)
  - on the last word (index = BURST), also assert rx_done in the same cycle, then WAIT_LOW.
- Output timing: all strobes are registered and asserted in the cycle after the clock edge that samples the completing bit.
- WAIT_LOW: ignore rx_bit; move to IDLE on the first edge with master_valid=0. selected is cleared on entry to WAIT_LOW.
- Truncation: master_valid=0 in SEL..DATA before the frame completes:
  - if selected=1: pulse frame_err
  - in all cases: clear selected and go to IDLE
  - writes already issued stand; the partial word is discarded.
- master_valid held high across frames: a new frame is recognised only after at least one low cycle (WAIT_LOW).
- BURST = 2^BURST_SIZE - 1 is legal. The word index counter is BURST_SIZE bits wide and must not overflow before the compare.
- rst asserted mid-frame: immediate return to reset values; no strobe may appear after rst deasserts until a new complete frame is received.
- mem_wen and read_req are never high in the same cycle.

Test Plan:
- SLAVE_ID=1, write frame (SEL=01, CMD=1, ADDR=0x005, BURST=0, DATA=0xA5; 35 bits) -> exactly one mem_wen with mem_addr=0x005, mem_wdata=0xA5, rx_done in the same cycle; slave_ready=1 one cycle after master_valid falls.
- Write with ADDR=0xFFF, BURST=2, data 0x11,0x22,0x33 -> three mem_wen pulses spaced 8 cycles apart, at addresses 0xFFF, 0x000, 0x001; rx_done with the third pulse only.
- Read frame (SEL=01, CMD=0, ADDR=0x0A0, BURST=3) -> one read_req with read_addr=0x0A0, read_burst_num=3, plus rx_done; no mem_wen.
- Frame with SEL=10 -> selected stays 0; no mem_wen, read_req, rx_done or frame_err; slave_ready returns after master_valid falls; an immediately following SEL=01 frame is accepted.
- Write BURST=1 with master_valid dropped 3 bits into the second word -> first word written, then frame_err pulse, no rx_done, state IDLE.
- rst pulsed during ADDR of a selected frame -> outputs at reset values within the reset cycle; the remaining bits of that frame after deassert cause no strobes.
